// File: rtl/scumv_uart_pkg.sv
// Shared definitions for the UART packet assembler: default packet geometry,
// FSM state encoding and a width helper for counters and byte indices.
// Imported by uart_packet_assembler and idle_timer.
package scumv_uart_pkg;

  localparam int PKT_BYTES_DEFAULT = 16;
  localparam int PKT_WIDTH         = PKT_BYTES_DEFAULT * 8;
  localparam int BYTE_IDX_W        = $clog2(PKT_BYTES_DEFAULT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // byte count 0
    COLLECT = 2'd1,  // byte count 1..PKT_BYTES-1
    FULL    = 2'd2   // complete packet held for the bridge
  } state_e;

  // Bits needed to hold 0..n-1; never less than 1 so a count of one
  // still produces a legal vector.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_packet_assembler_idle_timer.sv
// idle_timer: counts enabled cycles and pulses expire_o on the cycle the
// count reaches TIMEOUT_CYCLES-1; clear_i wins over counting and expiry.
// Ports: clk_i, rst_ni (async low), clear_i, enable_i -> expire_o (comb pulse).
module idle_timer
  import scumv_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int               CNT_W = width_for(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear on the same cycle (a byte arriving) suppresses expiry.
  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_packet_assembler.sv
// uart_packet_assembler: gathers PKT_BYTES UART bytes (first byte at [7:0])
// into one packet and hands it to a TileLink bridge with valid/ready.
// Ports: sysclk, reset_n (async assert, synchronised release); rx_valid/
// rx_ready/rx_data byte input; packet_valid/packet_ready/packet_data output;
// overrun_err (sticky), timeout_pulse, pkt_count (16-bit wrapping).
// Macro UART_PKT_TIMEOUT_EN adds an inter-byte idle timeout that discards a
// partial packet; without it timeout_pulse is tied low and partials wait.
module uart_packet_assembler
  import scumv_uart_pkg::*;
#(
  parameter int PKT_BYTES      = PKT_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [7:0]             rx_data,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic [PKT_BYTES*8-1:0] packet_data,
  output logic                   overrun_err,
  output logic                   timeout_pulse,
  output logic [15:0]            pkt_count
);

  localparam int               IDX_W    = width_for(PKT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  if (PKT_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_packet_assembler: PKT_BYTES and TIMEOUT_CYCLES must be >= 1");
  end

  // Reset asserts asynchronously through both flops, so everything clears
  // at once; release reaches the logic two sysclk edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PKT_BYTES*8-1:0] data_q, data_d;
  logic                   ovr_q, ovr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   accept;
  logic                   expire;

  assign rx_ready     = (state_q != FULL);
  assign packet_valid = (state_q == FULL);
  assign packet_data  = data_q;
  assign overrun_err  = ovr_q;
  assign pkt_count    = cnt_q;
  assign accept       = rx_valid && rx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // Bytes offered while FULL are dropped; the held packet is untouched.
    ovr_d   = ovr_q | (rx_valid & ~rx_ready);

    unique case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          data_d[{idx_q, 3'b000} +: 8] = rx_data;
          if (idx_q == LAST_IDX) begin
            state_d = FULL;
            idx_d   = '0;
          end else begin
            state_d = COLLECT;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else if (expire) begin
          // Only reachable in COLLECT: the timer is held clear elsewhere.
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      FULL: begin
        // rx_ready is low here, so no byte can land in the handoff cycle.
        if (packet_ready) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  logic timer_clr;
  logic timer_en;
  logic tmo_q;

  // Timer runs only in COLLECT and restarts on every accepted byte.
  assign timer_en  = (state_q == COLLECT);
  assign timer_clr = accept || (state_q != COLLECT);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .clear_i (timer_clr),
    .enable_i(timer_en),
    .expire_o(expire)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= expire;
    end
  end

  assign timeout_pulse = tmo_q;
`else
  assign expire        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_packet_assembler.sv
module tb_uart_packet_assembler;

  logic         sysclk = 1'b0;
  logic         reset_n;
  logic         rx_valid, rx_ready, packet_valid, packet_ready;
  logic         overrun_err, timeout_pulse;
  logic [7:0]   rx_data;
  logic [127:0] packet_data;
  logic [15:0]  pkt_count;

  logic         w_rx_valid, w_rx_ready, w_packet_valid, w_packet_ready;
  logic         w_overrun, w_timeout;
  logic [7:0]   w_rx_data, w_packet_data;
  logic [15:0]  w_pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sysclk = ~sysclk;

  uart_packet_assembler #(.PKT_BYTES(16), .TIMEOUT_CYCLES(100)) dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_data(packet_data),
    .overrun_err(overrun_err), .timeout_pulse(timeout_pulse), .pkt_count(pkt_count)
  );

  // Single-byte packets: fastest way to drive the packet counter through wrap.
  uart_packet_assembler #(.PKT_BYTES(1)) dut_w (
    .sysclk(sysclk), .reset_n(reset_n),
    .rx_valid(w_rx_valid), .rx_ready(w_rx_ready), .rx_data(w_rx_data),
    .packet_valid(w_packet_valid), .packet_ready(w_packet_ready), .packet_data(w_packet_data),
    .overrun_err(w_overrun), .timeout_pulse(w_timeout), .pkt_count(w_pkt_count)
  );

  typedef struct {
    logic         rv;
    logic [7:0]   rd;
    logic         pr;
    logic         e_rdy;
    logic         e_pv;
    logic         e_ovr;
    logic [15:0]  e_cnt;
    logic         chk_dat;
    logic [127:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] D_BASIC = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D_BP    = 128'h3F3E3D3C3B3A39383736353433323130;
  localparam logic [127:0] D_RST   = 128'h6F6E6D6C6B6A69686766656463626160;
  localparam logic [127:0] D_TMO   = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] D_COLL  = 128'h8A898887868584838281807473727170;

  function automatic vec_t mk(logic rv, logic [7:0] rd, logic pr, logic e_rdy,
                              logic e_pv, logic e_ovr, logic [15:0] e_cnt,
                              logic chk_dat, logic [127:0] e_dat);
    vec_t v;
    v.rv = rv; v.rd = rd; v.pr = pr; v.e_rdy = e_rdy; v.e_pv = e_pv;
    v.e_ovr = e_ovr; v.e_cnt = e_cnt; v.chk_dat = chk_dat; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic handoff(input logic [15:0] exp_cnt, input string tag);
    packet_ready = 1'b1;
    tick();
    packet_ready = 1'b0;
    chk({tag, " handoff packet_valid"}, packet_valid, 1'b0);
    chk({tag, " handoff pkt_count"}, pkt_count, exp_cnt);
  endtask

  initial begin
    int pulses;
    int pulse_at;

    reset_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; packet_ready = 1'b0;
    w_rx_valid = 1'b0; w_rx_data = 8'h00; w_packet_ready = 1'b0;

    // Basic packet, then backpressure with overrun, then stray packet_ready.
    for (int i = 0; i < 15; i++) vecs.push_back(mk(1, 8'(i), 1, 1, 0, 0, 16'd0, 0, '0));
    vecs.push_back(mk(1, 8'h0F, 1, 0, 1, 0, 16'd0, 1, D_BASIC));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 16'd1, 0, '0));
    for (int i = 0; i < 15; i++) vecs.push_back(mk(1, 8'(8'h30 + i), 0, 1, 0, 0, 16'd1, 0, '0));
    vecs.push_back(mk(1, 8'h3F, 0, 0, 1, 0, 16'd1, 1, D_BP));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 1, 16'd1, 1, D_BP));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 16'd2, 0, '0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 16'd2, 0, '0));

    #2 reset_n = 1'b0;
    tick(); tick();
    chk("reset rx_ready", rx_ready, 1'b1);
    chk("reset packet_valid", packet_valid, 1'b0);
    chk("reset packet_data", packet_data, '0);
    chk("reset overrun_err", overrun_err, 1'b0);
    chk("reset timeout_pulse", timeout_pulse, 1'b0);
    chk("reset pkt_count", pkt_count, 16'd0);
    reset_n = 1'b1;
    tick(); tick(); tick();

    foreach (vecs[i]) begin
      rx_valid     = vecs[i].rv;
      rx_data      = vecs[i].rd;
      packet_ready = vecs[i].pr;
      tick();
      chk($sformatf("vec%0d rx_ready", i), rx_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d packet_valid", i), packet_valid, vecs[i].e_pv);
      chk($sformatf("vec%0d overrun_err", i), overrun_err, vecs[i].e_ovr);
      chk($sformatf("vec%0d pkt_count", i), pkt_count, vecs[i].e_cnt);
      chk($sformatf("vec%0d timeout_pulse", i), timeout_pulse, 1'b0);
      if (vecs[i].chk_dat) chk($sformatf("vec%0d packet_data", i), packet_data, vecs[i].e_dat);
    end
    rx_valid = 1'b0; packet_ready = 1'b0;

    // Reset mid-packet: outputs must clear without waiting for a clock edge.
    for (int i = 0; i < 8; i++) send_byte(8'(8'h50 + i));
    chk("midpkt collecting", rx_ready, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst rx_ready", rx_ready, 1'b1);
    chk("midrst packet_valid", packet_valid, 1'b0);
    chk("midrst packet_data", packet_data, '0);
    chk("midrst overrun_err", overrun_err, 1'b0);
    chk("midrst timeout_pulse", timeout_pulse, 1'b0);
    chk("midrst pkt_count", pkt_count, 16'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i));
    chk("postrst packet_valid", packet_valid, 1'b1);
    chk("postrst packet_data", packet_data, D_RST);
    handoff(16'd1, "postrst");

`ifdef UART_PKT_TIMEOUT_EN
    // Timeout: 5 bytes then silence; expiry lands on the 100th idle cycle.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i));
    pulses = 0; pulse_at = -1;
    for (int t = 1; t <= 110; t++) begin
      tick();
      if (timeout_pulse) begin pulses++; pulse_at = t; end
    end
    chk("timeout pulse count", 128'(pulses), 128'd1);
    chk("timeout pulse cycle", 128'(pulse_at), 128'd100);
    for (int i = 0; i < 15; i++) send_byte(8'(8'h10 + i));
    chk("timeout partial discarded", packet_valid, 1'b0);
    send_byte(8'h1F);
    chk("timeout next packet_valid", packet_valid, 1'b1);
    chk("timeout next packet_data", packet_data, D_TMO);
    handoff(16'd2, "timeout");

    // Collision: a byte arriving on the expiry cycle wins.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i));
    pulses = 0;
    for (int t = 1; t <= 99; t++) begin
      tick();
      if (timeout_pulse) pulses++;
    end
    chk("collision early pulses", 128'(pulses), 128'd0);
    send_byte(8'h80);
    chk("collision timeout_pulse", timeout_pulse, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h81 + i));
    chk("collision packet_valid", packet_valid, 1'b1);
    chk("collision packet_data", packet_data, D_COLL);
    handoff(16'd3, "collision");
`endif

    // Counter wrap: 65537 single-byte packets, two cycles each.
    w_rx_data = 8'h5A; w_rx_valid = 1'b1; w_packet_ready = 1'b1;
    tick();
    chk("wrap first packet_valid", w_packet_valid, 1'b1);
    chk("wrap first rx_ready", w_rx_ready, 1'b0);
    chk("wrap first packet_data", w_packet_data, 8'h5A);
    tick();
    chk("wrap first pkt_count", w_pkt_count, 16'd1);
    for (int i = 0; i < 65534; i++) begin tick(); tick(); end
    chk("wrap pkt_count 65535", w_pkt_count, 16'hFFFF);
    tick(); tick();
    chk("wrap pkt_count 65536", w_pkt_count, 16'h0000);
    tick(); tick();
    chk("wrap pkt_count 65537", w_pkt_count, 16'h0001);
    w_rx_valid = 1'b0; w_packet_ready = 1'b0;
    tick();
    chk("wrap idle packet_valid", w_packet_valid, 1'b0);
    chk("wrap overrun_err", w_overrun, 1'b1);
    chk("wrap timeout_pulse", w_timeout, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
